fixed_point_accumulator: RTL

- Downstream neighbour of fixed_point_multiplier in the perceptron datapath.
- Consumes the stream of sign-magnitude weight×input products, sums them, adds a bias, and presents one neuron pre-activation result per stream.
- Uses valid/ready handshakes on both sides so it can stall the multiplier feed or be stalled by the activation/output stage.

---
 rtl/fixed_point_pkg.sv | 36 +++
 rtl/saturating_adder.sv | 29 ++
 rtl/fixed_point_accumulator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point types for the perceptron datapath: sign-magnitude words,
// the accumulator FSM states and default-width conversion helpers.
package fixed_point_pkg;

  localparam int SIGN_W = 1;
  localparam int Q_M    = 16;
  localparam int Q_N    = 16;
  localparam int FIX_W  = SIGN_W + Q_M + Q_N;
  localparam int ACC_W  = Q_M + Q_N + 2;

  typedef struct packed {
    logic              sign;
    logic [Q_M+Q_N-1:0] mag;
  } fixed_sm_t;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} acc_state_t;

  // -0 maps to 0 naturally since negating a zero magnitude is still zero.
  function automatic acc_t sm_to_tc(input fixed_sm_t x);
    acc_t m;
    m = acc_t'({2'b00, x.mag});
    return x.sign ? -m : m;
  endfunction

  function automatic fixed_sm_t tc_to_sm(input acc_t x);
    fixed_sm_t r;
    acc_t      m;
    m      = x[ACC_W-1] ? -x : x;
    r.sign = x[ACC_W-1];
    r.mag  = m[Q_M+Q_N-1:0];
    return r;
  endfunction

endpackage

// File: rtl/saturating_adder.sv
// Two's-complement adder that clamps to +/-(2^MAG_W - 1) and flags the clamp.
module saturating_adder #(
  parameter int MAG_W = 32,
  localparam int AW   = MAG_W + 2
) (
  input  logic signed [AW-1:0] a_i,
  input  logic signed [AW-1:0] b_i,
  output logic signed [AW-1:0] sum_o,
  output logic                 ovf_o
);

  localparam logic signed [AW:0] MAXV = {3'b000, {MAG_W{1'b1}}};

  logic signed [AW:0] raw;

  always_comb begin
    raw   = {a_i[AW-1], a_i} + {b_i[AW-1], b_i};
    sum_o = AW'(raw);
    ovf_o = 1'b0;
    if (raw > MAXV) begin
      sum_o = AW'(MAXV);
      ovf_o = 1'b1;
    end else if (raw < -MAXV) begin
      sum_o = AW'(-MAXV);
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Sums a stream of sign-magnitude products, adds a bias and hands off one
// pre-activation per stream. Optional FIXED_POINT_ACCUMULATOR_RELU_EN clamps
// negative post-bias results to zero.
module fixed_point_accumulator
  import fixed_point_pkg::*;
#(
  parameter int sign      = SIGN_W,
  parameter int q_m       = Q_M,
  parameter int q_n       = Q_N,
  parameter int MAX_TERMS = 16,
  localparam int W        = sign + q_m + q_n,
  localparam int MW       = q_m + q_n,
  localparam int AW       = MW + 2,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [W-1:0]  product_in,
  input  logic          product_valid_i,
  input  logic          product_last_i,
  output logic          product_ready_o,
  input  logic [W-1:0]  bias_in,
  output logic [W-1:0]  sum_out,
  output logic          sum_valid_o,
  input  logic          sum_ready_i,
  output logic          overflow_o,
  output logic [CW-1:0] term_count_o
);

  acc_state_t           state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                 ovf_q, ovf_d;
  logic                 rdy_q, rdy_d;
  logic                 vld_q, vld_d;
  logic [W-1:0]         sum_q, sum_d;

  logic signed [AW-1:0] prod_tc, bias_tc, add_b, add_sum, bias_res;
  logic                 add_ovf, res_neg;
  logic [MW-1:0]        res_mag;

  always_comb begin
    prod_tc = AW'({2'b00, product_in[MW-1:0]});
    if (product_in[W-1]) prod_tc = -prod_tc;
    bias_tc = AW'({2'b00, bias_in[MW-1:0]});
    if (bias_in[W-1]) bias_tc = -bias_tc;
    add_b = (state_q == BIAS) ? bias_tc : prod_tc;
  end

  // One adder serves both the accumulate and the bias step.
  saturating_adder #(.MAG_W(MW)) u_add (
    .a_i  (acc_q),
    .b_i  (add_b),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
`ifdef FIXED_POINT_ACCUMULATOR_RELU_EN
    bias_res = add_sum[AW-1] ? '0 : add_sum;
`else
    bias_res = add_sum;
`endif
    res_neg = bias_res[AW-1];
    res_mag = res_neg ? MW'(-bias_res) : MW'(bias_res);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    sum_d   = sum_q;
    cnt_inc = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        state_d = ACCUM;
        rdy_d   = 1'b1;
      end
      ACCUM: begin
        if (product_valid_i && rdy_q) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (product_last_i || cnt_inc == CW'(MAX_TERMS)) begin
            state_d = BIAS;
            rdy_d   = 1'b0;
          end
        end
      end
      BIAS: begin
        acc_d   = bias_res;
        ovf_d   = ovf_q | add_ovf;
        sum_d   = W'({res_neg, res_mag});
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (sum_ready_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          vld_d   = 1'b0;
          sum_d   = '0;
          rdy_d   = 1'b1;
          state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
    end
  end

  assign product_ready_o = rdy_q;
  assign sum_valid_o     = vld_q;
  assign sum_out         = sum_q;
  assign overflow_o      = ovf_q;
  assign term_count_o    = cnt_q;

endmodule
